// File: rtl/warp_scheduler_pkg.sv
// Shared types and widths for the warp scheduler: launch descriptor, per-core
// scheduling state and the narrow warp-id width used for reporting/comparison.
package warp_scheduler_pkg;

    localparam int PC_W                = 32;
    localparam int KERNEL_ID_W         = 8;
    localparam int WARP_ID_W           = 4;
    localparam int NUM_CORES_DEFAULT   = 4;
    localparam int QUEUE_DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic [PC_W-1:0]        start_pc;
        logic [KERNEL_ID_W-1:0] warp_id;
    } kernel_t;

    typedef enum logic [1:0] {
        CS_IDLE,
        CS_LAUNCH,
        CS_RUN,
        CS_DONE
    } core_sched_state_e;

    // Warp ids are only meaningful on the low WARP_ID_W bits once dispatched.
    function automatic logic [WARP_ID_W-1:0] shortWarpId(input kernel_t k);
        return k.warp_id[WARP_ID_W-1:0];
    endfunction

endpackage

// File: rtl/warp_scheduler_if.sv
// Host-facing handshakes of the warp scheduler: kernel launch (valid/ready)
// and retired-warp reporting (valid/ready). The host is the master side.
interface warp_scheduler_if;
    import warp_scheduler_pkg::*;

    logic                 kernel_valid;
    kernel_t              kernel_in;
    logic                 kernel_ready;

    logic                 done_valid;
    logic [WARP_ID_W-1:0] done_warp_id;
    logic                 done_ready;

    modport master (
        output kernel_valid, kernel_in, done_ready,
        input  kernel_ready, done_valid, done_warp_id
    );

    modport slave (
        input  kernel_valid, kernel_in, done_ready,
        output kernel_ready, done_valid, done_warp_id
    );

endinterface

// File: rtl/warp_scheduler_fifo.sv
// Synchronous FIFO of pending kernel descriptors. Head is read combinationally
// from the storage array; push is ignored when full, pop ignored when empty.
module kernel_fifo
    import warp_scheduler_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  kernel_t          push_data_i,
    input  logic             pop_i,
    output kernel_t          head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    kernel_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             pushFire;
    logic             popFire;

    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign head_o   = mem_q[rdPtr_q];
    assign pushFire = push_i && !full_o;
    assign popFire  = pop_i && !empty_o;

    // Occupancy next-state; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({pushFire, popFire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushFire) wrPtr_q <= wrPtr_q + 1'b1;
            if (popFire)  rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (pushFire) mem_q[wrPtr_q] <= push_data_i;
    end

endmodule

// File: rtl/warp_scheduler.sv
// Warp scheduler: queues kernel launch descriptors and dispatches one per cycle
// to the first idle core at or after a round-robin pointer. Each core runs a
// small IDLE/LAUNCH/RUN/DONE FSM; finished cores are reported lowest index first.
module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int NUM_CORES   = NUM_CORES_DEFAULT,
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT
) (
    input  logic                                clk,
    input  logic                                rst,
    warp_scheduler_if.slave                     host,
    output kernel_t [NUM_CORES-1:0]             core_kernel_out_o,
    output logic [NUM_CORES-1:0]                core_launch_o,
    input  logic [NUM_CORES-1:0]                core_finished_i,
    input  logic [NUM_CORES-1:0][WARP_ID_W-1:0] core_finished_id_i,
    output logic [NUM_CORES-1:0]                core_busy_o,
    output logic                                id_mismatch_err_o,
    output logic                                all_idle_o
);

    localparam int RR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    kernel_t                             fifoHead;
    logic                                fifoFull;
    logic                                fifoEmpty;
    logic [CNT_W-1:0]                    fifoCount;
    logic                                fifoPush;
    logic                                fifoPop;
    int                                  fifoCountNext;
    logic                                kernelReady_q;

    logic [RR_W-1:0]                     rrPtr_q;
    logic [NUM_CORES-1:0]                grantVec;
    logic [RR_W-1:0]                     grantIdx;
    logic                                grantValid;
    int                                  scanIdx;

    logic [NUM_CORES-1:0]                isIdle;
    logic [NUM_CORES-1:0]                isDone;
    logic [NUM_CORES-1:0]                mismatchVec;
    logic [NUM_CORES-1:0][WARP_ID_W-1:0] assignedId;

    logic                                reportValid;
    logic [RR_W-1:0]                     reportSel;
    logic [WARP_ID_W-1:0]                reportId;
    logic [NUM_CORES-1:0]                reportAck;

    logic                                idMismatch_q;

    assign fifoPush = host.kernel_valid && kernelReady_q && !fifoFull;
    assign fifoPop  = grantValid;

    kernel_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifoPush),
        .push_data_i (host.kernel_in),
        .pop_i       (fifoPop),
        .head_o      (fifoHead),
        .full_o      (fifoFull),
        .empty_o     (fifoEmpty),
        .count_o     (fifoCount)
    );

    // Predict the FIFO occupancy after this edge so kernel_ready can be a plain register.
    always_comb begin
        fifoCountNext = int'(fifoCount);
        if (fifoPush) fifoCountNext = fifoCountNext + 1;
        if (fifoPop)  fifoCountNext = fifoCountNext - 1;
    end

    // Registered ready: low in reset, otherwise high whenever the FIFO will not be full.
    always_ff @(posedge clk) begin
        if (!rst) begin
            kernelReady_q <= 1'b0;
        end else begin
            kernelReady_q <= (fifoCountNext != QUEUE_DEPTH);
        end
    end

    // Round-robin search for the first idle core at or after the pointer.
    always_comb begin
        grantVec   = '0;
        grantIdx   = '0;
        grantValid = 1'b0;
        scanIdx    = 0;
        for (int off = 0; off < NUM_CORES; off++) begin
            scanIdx = int'(rrPtr_q) + off;
            if (scanIdx >= NUM_CORES) scanIdx = scanIdx - NUM_CORES;
            if (!grantValid && !fifoEmpty && isIdle[scanIdx]) begin
                grantValid        = 1'b1;
                grantIdx          = RR_W'(scanIdx);
                grantVec[scanIdx] = 1'b1;
            end
        end
    end

    // Advance the pointer past the core just granted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rrPtr_q <= '0;
        end else if (grantValid) begin
            rrPtr_q <= (int'(grantIdx) == NUM_CORES - 1) ? '0 : grantIdx + 1'b1;
        end
    end

    // Fixed-priority report select: lowest-index DONE core wins.
    always_comb begin
        reportValid = 1'b0;
        reportSel   = '0;
        reportId    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!reportValid && isDone[i]) begin
                reportValid = 1'b1;
                reportSel   = RR_W'(i);
                reportId    = assignedId[i];
            end
        end
    end

    // The selected core retires only when the consumer takes the report.
    always_comb begin
        reportAck = '0;
        if (reportValid && host.done_ready) reportAck[reportSel] = 1'b1;
    end

    // Sticky id-mismatch flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idMismatch_q <= 1'b0;
        end else if (|mismatchVec) begin
            idMismatch_q <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        core_sched_state_e state_q;
        core_sched_state_e state_d;
        kernel_t           kernel_q;
        logic              mismatch;

        // Per-core next state; finish is ignored during LAUNCH so a stale level cannot retire a new warp.
        always_comb begin
            state_d  = state_q;
            mismatch = 1'b0;
            case (state_q)
                CS_IDLE:   if (grantVec[g]) state_d = CS_LAUNCH;
                CS_LAUNCH: state_d = CS_RUN;
                CS_RUN: begin
                    if (core_finished_i[g]) begin
                        state_d  = CS_DONE;
                        mismatch = (core_finished_id_i[g] != shortWarpId(kernel_q));
                    end
                end
                CS_DONE:   if (reportAck[g]) state_d = CS_IDLE;
                default:   state_d = CS_IDLE;
            endcase
        end

        // Per-core state and descriptor registers; the descriptor loads from the FIFO head on grant.
        always_ff @(posedge clk) begin
            if (!rst) begin
                state_q  <= CS_IDLE;
                kernel_q <= '0;
            end else begin
                state_q <= state_d;
                if (grantVec[g]) kernel_q <= fifoHead;
            end
        end

        assign isIdle[g]            = (state_q == CS_IDLE);
        assign isDone[g]            = (state_q == CS_DONE);
        assign mismatchVec[g]       = mismatch;
        assign assignedId[g]        = shortWarpId(kernel_q);
        assign core_launch_o[g]     = (state_q == CS_LAUNCH);
        assign core_busy_o[g]       = (state_q != CS_IDLE);
        assign core_kernel_out_o[g] = kernel_q;
    end

    assign host.kernel_ready = kernelReady_q;
    assign host.done_valid   = reportValid;
    assign host.done_warp_id = reportId;
    assign id_mismatch_err_o = idMismatch_q;
    assign all_idle_o        = fifoEmpty && (&isIdle);

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler: a table of per-cycle vectors for reset,
// single warp, id truncation/mismatch and stale finish, then hand-written
// sequences for round-robin/backpressure, simultaneous finish and mid-run reset.
module tb_warp_scheduler;
    import warp_scheduler_pkg::*;

    localparam int NC       = 4;
    localparam int NUM_VECS = 25;

    typedef struct {
        logic        rstN;
        logic        kValid;
        logic [31:0] kPc;
        logic [7:0]  kId;
        logic [3:0]  fin;
        logic [3:0]  finId;
        logic        dReady;
        logic        eReady;
        logic [3:0]  eLaunch;
        logic [3:0]  eBusy;
        logic        eDValid;
        logic [3:0]  eDId;
        logic        eErr;
        logic        eIdle;
        logic [31:0] ePc0;
    } vector_t;

    typedef struct {
        int         core;
        logic [3:0] id;
    } launch_rec_t;

    logic                         clk;
    logic                         rst;
    kernel_t [NC-1:0]             coreKernel;
    logic [NC-1:0]                coreLaunch;
    logic [NC-1:0]                coreFinished;
    logic [NC-1:0][WARP_ID_W-1:0] coreFinishedId;
    logic [NC-1:0]                coreBusy;
    logic                         idErr;
    logic                         allIdle;

    int          checks = 0;
    int          errors = 0;
    vector_t     vecs [NUM_VECS];
    launch_rec_t launchLog [$];
    logic        logLaunches = 1'b0;
    int          pushIdx;
    logic        accepted;

    warp_scheduler_if hostIf ();

    warp_scheduler #(
        .NUM_CORES   (NC),
        .QUEUE_DEPTH (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .host               (hostIf),
        .core_kernel_out_o  (coreKernel),
        .core_launch_o      (coreLaunch),
        .core_finished_i    (coreFinished),
        .core_finished_id_i (coreFinishedId),
        .core_busy_o        (coreBusy),
        .id_mismatch_err_o  (idErr),
        .all_idle_o         (allIdle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every launch pulse (core, id) away from the active edge.
    always @(negedge clk) begin
        if (logLaunches) begin
            for (int i = 0; i < NC; i++) begin
                if (coreLaunch[i]) launchLog.push_back('{i, coreKernel[i].warp_id[3:0]});
            end
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vector_t v);
        rst                 = v.rstN;
        hostIf.kernel_valid = v.kValid;
        hostIf.kernel_in    = '{start_pc: v.kPc, warp_id: v.kId};
        hostIf.done_ready   = v.dReady;
        coreFinished        = v.fin;
        for (int i = 0; i < NC; i++) coreFinishedId[i] = v.finId;
    endtask

    task automatic checkOutput(input vector_t v, input int idx);
        check($sformatf("v%0d.ready", idx),  32'(hostIf.kernel_ready), 32'(v.eReady));
        check($sformatf("v%0d.launch", idx), 32'(coreLaunch),          32'(v.eLaunch));
        check($sformatf("v%0d.busy", idx),   32'(coreBusy),            32'(v.eBusy));
        check($sformatf("v%0d.dvalid", idx), 32'(hostIf.done_valid),   32'(v.eDValid));
        check($sformatf("v%0d.did", idx),    32'(hostIf.done_warp_id), 32'(v.eDId));
        check($sformatf("v%0d.err", idx),    32'(idErr),               32'(v.eErr));
        check($sformatf("v%0d.idle", idx),   32'(allIdle),             32'(v.eIdle));
        check($sformatf("v%0d.pc0", idx),    coreKernel[0].start_pc,   v.ePc0);
    endtask

    task automatic loadVectors();
        //          rstN  kV    kPc       kId    fin   finId dR     eRdy eLaunch eBusy eDV  eDId  eErr eIdle ePc0
        vecs[0]  = '{1'b0, 1'b1, 32'hAAA, 8'h01, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 32'h000};
        vecs[1]  = '{1'b0, 1'b1, 32'hAAA, 8'h01, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 32'h000};
        vecs[2]  = '{1'b0, 1'b1, 32'hAAA, 8'h01, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 32'h000};
        vecs[3]  = '{1'b1, 1'b1, 32'hAAA, 8'h01, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 32'h000};
        vecs[4]  = '{1'b1, 1'b0, 32'h000, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 32'h000};
        vecs[5]  = '{1'b1, 1'b1, 32'h100, 8'h03, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 32'h000};
        vecs[6]  = '{1'b1, 1'b0, 32'h000, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h000};
        vecs[7]  = '{1'b1, 1'b0, 32'h000, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 32'h100};
        vecs[8]  = '{1'b1, 1'b0, 32'h000, 8'h00, 4'h1, 4'h3, 1'b0, 1'b1, 4'h0, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 32'h100};
        vecs[9]  = '{1'b1, 1'b0, 32'h000, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h1, 1'b1, 4'h3, 1'b0, 1'b0, 32'h100};
        vecs[10] = '{1'b1, 1'b0, 32'h000, 8'h00, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 4'h1, 1'b1, 4'h3, 1'b0, 1'b0, 32'h100};
        vecs[11] = '{1'b1, 1'b0, 32'h000, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 32'h100};
        vecs[12] = '{1'b1, 1'b1, 32'h200, 8'h15, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 32'h100};
        vecs[13] = '{1'b1, 1'b0, 32'h000, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h100};
        vecs[14] = '{1'b1, 1'b0, 32'h000, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 4'h2, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 32'h100};
        vecs[15] = '{1'b1, 1'b0, 32'h000, 8'h00, 4'h2, 4'h6, 1'b0, 1'b1, 4'h0, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 32'h100};
        vecs[16] = '{1'b1, 1'b0, 32'h000, 8'h00, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 4'h2, 1'b1, 4'h5, 1'b1, 1'b0, 32'h100};
        vecs[17] = '{1'b1, 1'b0, 32'h000, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 32'h100};
        vecs[18] = '{1'b1, 1'b1, 32'h300, 8'h07, 4'hF, 4'h7, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 32'h100};
        vecs[19] = '{1'b1, 1'b0, 32'h000, 8'h00, 4'hF, 4'h7, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 32'h100};
        vecs[20] = '{1'b1, 1'b0, 32'h000, 8'h00, 4'hF, 4'h7, 1'b0, 1'b1, 4'h4, 4'h4, 1'b0, 4'h0, 1'b1, 1'b0, 32'h100};
        vecs[21] = '{1'b1, 1'b0, 32'h000, 8'h00, 4'hF, 4'h7, 1'b0, 1'b1, 4'h0, 4'h4, 1'b0, 4'h0, 1'b1, 1'b0, 32'h100};
        vecs[22] = '{1'b1, 1'b0, 32'h000, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h4, 1'b1, 4'h7, 1'b1, 1'b0, 32'h100};
        vecs[23] = '{1'b1, 1'b0, 32'h000, 8'h00, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 4'h4, 1'b1, 4'h7, 1'b1, 1'b0, 32'h100};
        vecs[24] = '{1'b1, 1'b0, 32'h000, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 32'h100};
    endtask

    task automatic doReset();
        rst                 = 1'b0;
        hostIf.kernel_valid = 1'b0;
        hostIf.done_ready   = 1'b0;
        coreFinished        = '0;
        step();
        step();
        rst = 1'b1;
        step();
        check("rst.ready", 32'(hostIf.kernel_ready), 32'd1);
        check("rst.idle",  32'(allIdle),             32'd1);
        check("rst.err",   32'(idErr),               32'd0);
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst                 = 1'b0;
        hostIf.kernel_valid = 1'b0;
        hostIf.kernel_in    = '0;
        hostIf.done_ready   = 1'b0;
        coreFinished        = '0;
        coreFinishedId      = '0;
        loadVectors();
        step();

        // Reset, single warp, truncation + mismatch, stale finish.
        for (int v = 0; v < NUM_VECS; v++) begin
            applyStimulus(vecs[v]);
            checkOutput(vecs[v], v);
            step();
        end

        // Round-robin and backpressure: twelve pushes, cores never finish.
        doReset();
        launchLog.delete();
        logLaunches = 1'b1;
        pushIdx     = 0;
        for (int cyc = 0; cyc < 40 && pushIdx < 12; cyc++) begin
            hostIf.kernel_valid = 1'b1;
            hostIf.kernel_in    = '{start_pc: 32'h1000 + 32'(pushIdx) * 4, warp_id: 8'(pushIdx)};
            accepted            = hostIf.kernel_ready;
            step();
            if (accepted) pushIdx++;
        end
        hostIf.kernel_valid = 1'b0;
        check("bp.pushed", 32'(pushIdx), 32'd12);
        repeat (3) step();
        check("bp.ready_full", 32'(hostIf.kernel_ready), 32'd0);
        check("bp.busy_all",   32'(coreBusy),            32'hF);
        check("bp.idle",       32'(allIdle),             32'd0);
        check("bp.nlaunch",    32'(launchLog.size()),    32'd4);
        for (int i = 0; i < 4 && i < launchLog.size(); i++) begin
            check($sformatf("bp.launch%0d.core", i), 32'(launchLog[i].core), 32'(i));
            check($sformatf("bp.launch%0d.id", i),   32'(launchLog[i].id),   32'(i));
        end

        // Finish core 2; it is reused for id 4 while the FIFO pops from full.
        coreFinished      = 4'b0100;
        coreFinishedId[2] = 4'd2;
        step();
        coreFinished = '0;
        check("bp.c2.dvalid", 32'(hostIf.done_valid),   32'd1);
        check("bp.c2.did",    32'(hostIf.done_warp_id), 32'd2);
        hostIf.done_ready = 1'b1;
        step();
        hostIf.done_ready = 1'b0;
        check("bp.c2.idle_busy", 32'(coreBusy),            32'hB);
        check("bp.pop_ready",    32'(hostIf.kernel_ready), 32'd0);
        step();
        check("bp.c2.launch",  32'(coreLaunch),                32'h4);
        check("bp.c2.id",      32'(coreKernel[2].warp_id),     32'd4);
        check("bp.c2.pc",      coreKernel[2].start_pc,         32'h1010);
        check("bp.ready_back", 32'(hostIf.kernel_ready),       32'd1);
        step();

        // Simultaneous finish on cores 1 and 3; stall five cycles, then drain.
        coreFinished      = 4'b1010;
        coreFinishedId[1] = 4'd1;
        coreFinishedId[3] = 4'd3;
        step();
        coreFinished = '0;
        for (int s = 0; s < 5; s++) begin
            check($sformatf("sim.stall%0d.dvalid", s), 32'(hostIf.done_valid),   32'd1);
            check($sformatf("sim.stall%0d.did", s),    32'(hostIf.done_warp_id), 32'd1);
            step();
        end
        hostIf.done_ready = 1'b1;
        check("sim.first.did", 32'(hostIf.done_warp_id), 32'd1);
        step();
        check("sim.second.dvalid", 32'(hostIf.done_valid),   32'd1);
        check("sim.second.did",    32'(hostIf.done_warp_id), 32'd3);
        step();
        hostIf.done_ready = 1'b0;
        check("sim.drained", 32'(hostIf.done_valid), 32'd0);
        check("sim.err",     32'(idErr),             32'd0);
        logLaunches = 1'b0;
        check("bp.nlaunch5", 32'(launchLog.size() >= 5), 32'd1);
        if (launchLog.size() >= 5) begin
            check("bp.launch4.core", 32'(launchLog[4].core), 32'd2);
            check("bp.launch4.id",   32'(launchLog[4].id),   32'd4);
        end

        // Reset mid-run with a DONE core, running cores and queued warps.
        coreFinished      = 4'b0001;
        coreFinishedId[0] = 4'd0;
        step();
        coreFinished = '0;
        check("mid.pre.dvalid", 32'(hostIf.done_valid), 32'd1);
        check("mid.pre.idle",   32'(allIdle),           32'd0);
        rst = 1'b0;
        step();
        check("mid.busy",   32'(coreBusy),            32'h0);
        check("mid.launch", 32'(coreLaunch),          32'h0);
        check("mid.dvalid", 32'(hostIf.done_valid),   32'd0);
        check("mid.did",    32'(hostIf.done_warp_id), 32'd0);
        check("mid.idle",   32'(allIdle),             32'd1);
        check("mid.ready",  32'(hostIf.kernel_ready), 32'd0);
        rst = 1'b1;
        step();
        check("mid.ready_after", 32'(hostIf.kernel_ready), 32'd1);
        repeat (3) step();
        check("mid.nolaunch", 32'(coreLaunch), 32'h0);
        check("mid.nobusy",   32'(coreBusy),   32'h0);
        check("mid.empty",    32'(allIdle),    32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
